// File: rtl/insn_encoder.sv
// insn_encoder: turns an encode request (format, opcode, function fields,
// register numbers, byte-offset immediate) into an RV32I instruction word.
// Requests whose immediate cannot be represented, or whose format code is
// unknown, produce a canonical NOP (addi x0,x0,0) flagged with out_err.
// Encoded words pass through a 2-entry FIFO so that a stalled consumer
// does not immediately stall the producer. A 16-bit counter tallies words
// handed to the consumer.
module insn_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_insn,
    output logic        out_err,
    output logic [15:0] out_count
);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [31:0] NOP_INSN  = 32'h0000_0013;
    localparam logic [1:0]  FIFO_FULL = 2'd2;

    typedef struct packed {
        logic        err;
        logic [31:0] insn;
    } entry_t;

    // ------------------------------------------------------------------
    // Immediate range qualifiers (signed interpretation of imm)
    // ------------------------------------------------------------------
    logic signed [31:0] imm_s;
    logic               imm_even;
    logic               fits_simm12;
    logic               fits_b_range;
    logic               fits_j_range;
    logic               u_low_clear;

    // Classify the immediate against every format's reachable range.
    always_comb begin
        imm_s        = $signed(imm);
        imm_even     = (imm[0] == 1'b0);
        fits_simm12  = (imm_s >= -32'sd2048)    && (imm_s <= 32'sd2047);
        fits_b_range = (imm_s >= -32'sd4096)    && (imm_s <= 32'sd4094) && imm_even;
        fits_j_range = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && imm_even;
        u_low_clear  = (imm[11:0] == 12'h000);
    end

    // ------------------------------------------------------------------
    // Per-format word assembly
    // ------------------------------------------------------------------
    logic [31:0] word_r;
    logic [31:0] word_i;
    logic [31:0] word_s;
    logic [31:0] word_b;
    logic [31:0] word_u;
    logic [31:0] word_j;

    // Build all six candidate layouts in parallel; the format code picks one.
    always_comb begin
        word_r = {funct7, rs2, rs1, funct3, rd, opcode};
        word_i = {imm[11:0], rs1, funct3, rd, opcode};
        word_s = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        word_b = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        word_u = {imm[31:12], rd, opcode};
        word_j = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
    end

    logic [31:0] enc_word;
    logic        enc_legal;
    entry_t      enc_entry;

    // Select the layout for the requested format and decide legality;
    // anything illegal is replaced by a NOP carrying the error flag.
    always_comb begin
        enc_word  = NOP_INSN;
        enc_legal = 1'b0;
        unique case (fmt)
            FMT_R: begin
                enc_word  = word_r;
                enc_legal = 1'b1;
            end
            FMT_I: begin
                enc_word  = word_i;
                enc_legal = fits_simm12;
            end
            FMT_S: begin
                enc_word  = word_s;
                enc_legal = fits_simm12;
            end
            FMT_B: begin
                enc_word  = word_b;
                enc_legal = fits_b_range;
            end
            FMT_U: begin
                enc_word  = word_u;
                enc_legal = u_low_clear;
            end
            FMT_J: begin
                enc_word  = word_j;
                enc_legal = fits_j_range;
            end
            default: begin
                enc_word  = NOP_INSN;
                enc_legal = 1'b0;
            end
        endcase

        enc_entry.err  = !enc_legal;
        enc_entry.insn = enc_legal ? enc_word : NOP_INSN;
    end

    // ------------------------------------------------------------------
    // 2-entry FIFO of {err, insn} plus delivered-word counter
    // ------------------------------------------------------------------
    entry_t      mem_q [2];
    entry_t      mem_d [2];
    logic        wr_ptr_q;
    logic        wr_ptr_d;
    logic        rd_ptr_q;
    logic        rd_ptr_d;
    logic [1:0]  count_q;
    logic [1:0]  count_d;
    logic [15:0] out_count_q;
    logic [15:0] out_count_d;

    logic        push;
    logic        pop;

    // Handshake flags come from registered occupancy only, so in_ready has
    // no combinational dependence on out_ready.
    always_comb begin
        in_ready  = (count_q != FIFO_FULL);
        out_valid = (count_q != 2'd0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        out_insn  = mem_q[rd_ptr_q].insn;
        out_err   = mem_q[rd_ptr_q].err;
        out_count = out_count_q;
    end

    // Next-state for storage, pointers, occupancy and delivered count.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = enc_entry;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        out_count_d = pop ? (out_count_q + 16'd1) : out_count_q;
    end

    // Register update; reset drops any queued words and clears the head so
    // out_insn/out_err read zero while empty after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            out_count_q <= 16'd0;
        end else begin
            mem_q[0]    <= mem_d[0];
            mem_q[1]    <= mem_d[1];
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_count_q <= out_count_d;
        end
    end

endmodule

// File: tb/tb_insn_encoder.sv
// Bench for insn_encoder: directed vector table, handshake sequences and a
// randomized run scored against a queue-based reference model.
module tb_insn_encoder;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_insn;
    logic        out_err;
    logic [15:0] out_count;

    int checks;
    int failures;

    insn_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fmt       (fmt),
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7    (funct7),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_insn  (out_insn),
        .out_err   (out_err),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp_insn;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string nm, logic [2:0] f, logic [6:0] op, logic [2:0] f3,
                                logic [6:0] f7, logic [4:0] d, logic [4:0] s1, logic [4:0] s2,
                                logic [31:0] im, logic [31:0] ei, logic ee);
        vec_t v;
        v.name = nm; v.fmt = f; v.opcode = op; v.funct3 = f3; v.funct7 = f7;
        v.rd = d; v.rs1 = s1; v.rs2 = s2; v.imm = im; v.exp_insn = ei; v.exp_err = ee;
        return v;
    endfunction

    // Reference: arithmetic on 64-bit integers, fields placed by shifting.
    function automatic logic [32:0] ref_enc(logic [2:0] f, logic [6:0] op, logic [2:0] f3,
                                            logic [6:0] f7, logic [4:0] d, logic [4:0] s1,
                                            logic [4:0] s2, logic [31:0] im);
        longint s, u, w;
        longint lop, lf3, lf7, ld, ls1, ls2;
        bit ok;
        logic [32:0] r;
        s = longint'($signed(im));
        u = longint'(im);
        lop = longint'(op); lf3 = longint'(f3); lf7 = longint'(f7);
        ld = longint'(d); ls1 = longint'(s1); ls2 = longint'(s2);
        ok = 0;
        w = 0;
        case (f)
            3'd0: begin
                ok = 1;
                w = (lf7 << 25) | (ls2 << 20) | (ls1 << 15) | (lf3 << 12) | (ld << 7) | lop;
            end
            3'd1: begin
                ok = (s >= -2048) && (s <= 2047);
                w = ((u % 4096) << 20) | (ls1 << 15) | (lf3 << 12) | (ld << 7) | lop;
            end
            3'd2: begin
                ok = (s >= -2048) && (s <= 2047);
                w = (((u / 32) % 128) << 25) | (ls2 << 20) | (ls1 << 15) | (lf3 << 12)
                    | ((u % 32) << 7) | lop;
            end
            3'd3: begin
                ok = (s >= -4096) && (s <= 4094) && (u % 2 == 0);
                w = (((u / 4096) % 2) << 31) | (((u / 32) % 64) << 25) | (ls2 << 20)
                    | (ls1 << 15) | (lf3 << 12) | (((u / 2) % 16) << 8)
                    | (((u / 2048) % 2) << 7) | lop;
            end
            3'd4: begin
                ok = (u % 4096 == 0);
                w = (u - (u % 4096)) | (ld << 7) | lop;
            end
            3'd5: begin
                ok = (s >= -1048576) && (s <= 1048574) && (u % 2 == 0);
                w = (((u / 1048576) % 2) << 31) | (((u / 2) % 1024) << 21)
                    | (((u / 2048) % 2) << 20) | (((u / 4096) % 256) << 12) | (ld << 7) | lop;
            end
            default: ok = 0;
        endcase
        if (!ok) w = 64'h13;
        r[31:0] = w[31:0];
        r[32]   = !ok;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(logic [2:0] f, logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                           logic [4:0] d, logic [4:0] s1, logic [4:0] s2, logic [31:0] im);
        fmt = f; opcode = op; funct3 = f3; funct7 = f7;
        rd = d; rs1 = s1; rs2 = s2; imm = im;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) step();
        reset = 1'b0;
    endtask

    logic [32:0] model_q[$];
    logic [32:0] exp_e;
    int          model_cnt;
    int          bvals[13];
    int          sent;
    int          delivered;
    bit          push, pop;

    initial begin
        checks = 0;
        failures = 0;
        bvals = '{-2049, -2048, 2047, 2048, -4096, -4098, 4094, 4096,
                  -1048576, -1048578, 1048574, 1048576, 3};
        set_req(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);

        vecs.push_back(mk("i_addi",   3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5,          32'h00500093, 1'b0));
        vecs.push_back(mk("s_sw",     3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8,          32'h0020A423, 1'b0));
        vecs.push_back(mk("b_neg4",   3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, -32'sd4,        32'hFE000EE3, 1'b0));
        vecs.push_back(mk("j_jal",    3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8,          32'h008000EF, 1'b0));
        vecs.push_back(mk("b_odd",    3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd3,          32'h00000013, 1'b1));
        vecs.push_back(mk("i_2048",   3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048,       32'h00000013, 1'b1));
        vecs.push_back(mk("fmt6",     3'd6, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0,          32'h00000013, 1'b1));
        vecs.push_back(mk("fmt7",     3'd7, 7'h33, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0,          32'h00000013, 1'b1));
        vecs.push_back(mk("r_sub",    3'd0, 7'h33, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'hDEADBEEF,  32'h403100B3, 1'b0));
        vecs.push_back(mk("i_2047",   3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2047,       32'h7FF00093, 1'b0));
        vecs.push_back(mk("i_m2048",  3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, -32'sd2048,     32'h80000093, 1'b0));
        vecs.push_back(mk("i_m2049",  3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, -32'sd2049,     32'h00000013, 1'b1));
        vecs.push_back(mk("b_4094",   3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd4094,       32'h7E000FE3, 1'b0));
        vecs.push_back(mk("b_4096",   3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd4096,       32'h00000013, 1'b1));
        vecs.push_back(mk("u_lui",    3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000,   32'h123452B7, 1'b0));
        vecs.push_back(mk("u_low",    3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345001,   32'h00000013, 1'b1));
        vecs.push_back(mk("j_max",    3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1048574,    32'h7FFFF0EF, 1'b0));
        vecs.push_back(mk("j_over",   3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1048576,    32'h00000013, 1'b1));

        // Reset state
        do_reset();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_count", 32'(out_count), 32'd0);
        chk("rst_out_insn",  out_insn,       32'd0);
        chk("rst_out_err",   32'(out_err),   32'd0);

        // Directed table, one word in flight, visible one cycle after accept
        for (int i = 0; i < vecs.size(); i++) begin
            set_req(vecs[i].fmt, vecs[i].opcode, vecs[i].funct3, vecs[i].funct7,
                    vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
            in_valid = 1'b1;
            out_ready = 1'b1;
            step();
            in_valid = 1'b0;
            chk({vecs[i].name, "_valid"}, 32'(out_valid), 32'd1);
            chk({vecs[i].name, "_insn"},  out_insn, vecs[i].exp_insn);
            chk({vecs[i].name, "_err"},   32'(out_err), 32'(vecs[i].exp_err));
        end
        step();
        chk("table_drained", 32'(out_valid), 32'd0);
        chk("table_count", 32'(out_count), 32'(vecs.size()));

        // Backpressure: three back-to-back requests with the consumer stalled
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        set_req(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
        step();
        set_req(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2);
        chk("bp_ready_1", 32'(in_ready), 32'd1);
        step();
        set_req(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd3);
        chk("bp_ready_full", 32'(in_ready), 32'd0);
        step();
        chk("bp_still_full", 32'(in_ready), 32'd0);
        chk("bp_head_stable", out_insn, 32'h00100093);
        out_ready = 1'b1;
        step();
        chk("bp_second", out_insn, 32'h00200093);
        chk("bp_ready_again", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp_third", out_insn, 32'h00300093);
        chk("bp_third_valid", 32'(out_valid), 32'd1);
        step();
        chk("bp_empty", 32'(out_valid), 32'd0);
        chk("bp_count", 32'(out_count), 32'd3);

        // Randomized run against the queue model
        do_reset();
        model_q.delete();
        model_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            chk("rnd_valid", 32'(out_valid), 32'(model_q.size() != 0));
            chk("rnd_ready", 32'(in_ready),  32'(model_q.size() < 2));
            chk("rnd_count", 32'(out_count), 32'(model_cnt % 65536));
            if (model_q.size() != 0) begin
                exp_e = model_q[0];
                chk("rnd_insn", out_insn, exp_e[31:0]);
                chk("rnd_err",  32'(out_err), 32'(exp_e[32]));
            end
            fmt = 3'($urandom_range(0, 7));
            opcode = 7'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
            rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
            case ($urandom_range(0, 4))
                0: imm = $urandom;
                1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                2: imm = 32'(bvals[$urandom_range(0, 12)]);
                3: imm = $urandom & 32'hFFFFF000;
                default: imm = (32'($urandom_range(0, 2097151)) - 32'd1048576) & 32'hFFFFFFFE;
            endcase
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            push = in_valid && (model_q.size() < 2);
            pop  = out_ready && (model_q.size() != 0);
            exp_e = ref_enc(fmt, opcode, funct3, funct7, rd, rs1, rs2, imm);
            @(posedge clk);
            if (pop) begin
                void'(model_q.pop_front());
                model_cnt++;
            end
            if (push) model_q.push_back(exp_e);
            @(negedge clk);
        end

        // Stream 65537 words: delivered count wraps past 16 bits
        do_reset();
        set_req(3'd0, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0);
        in_valid = 1'b1;
        out_ready = 1'b1;
        sent = 0;
        delivered = 0;
        for (int c = 0; c < 70000; c++) begin
            if (sent == 65537 && !out_valid) break;
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) delivered++;
            step();
            if (sent == 65537) in_valid = 1'b0;
        end
        chk("stream_sent", 32'(sent), 32'd65537);
        chk("stream_delivered", 32'(delivered), 32'd65537);
        chk("stream_count_wrap", 32'(out_count), 32'd1);

        // Reset with two entries queued discards them; no handshake in reset cycle
        out_ready = 1'b0;
        in_valid = 1'b1;
        set_req(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd7);
        repeat (2) step();
        chk("pend_full", 32'(in_ready), 32'd0);
        chk("pend_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        out_ready = 1'b1;
        step();
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("pend_rst_valid", 32'(out_valid), 32'd0);
        chk("pend_rst_count", 32'(out_count), 32'd0);
        chk("pend_rst_ready", 32'(in_ready),  32'd1);
        chk("pend_rst_insn",  out_insn,       32'd0);
        chk("pend_rst_err",   32'(out_err),   32'd0);
        step();
        chk("pend_stays_empty", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/insn_encoder.md
INSN_ENCODER -- requirements
Module: insn_encoder

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: reset  input  1  synchronous active-high reset.
REQ-004 Port: in_valid  input  1  encode request present.
REQ-005 Port: in_ready  output  1  request accepted this cycle when in_valid & in_ready.
REQ-006 Port: fmt  input  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7 illegal.
REQ-007 Port: opcode  input  7  major opcode, placed in insn[6:0] unchanged.
REQ-008 Port: funct3  input  3  insn[14:12] for R/I/S/B; ignored for U/J.
REQ-009 Port: funct7  input  7  insn[31:25] for R only; ignored otherwise.
REQ-010 Port: rd, rs1, rs2  input  5 each  register fields, used only where the format has them.
REQ-011 Port: imm  input  32  byte-offset immediate, two's complement; for U, the full 32-bit value.
REQ-012 Port: out_valid  output  1  encoded word available.
REQ-013 Port: out_ready  input  1  consumer takes the word when out_valid & out_ready.
REQ-014 Port: out_insn  output  32  encoded RV32I instruction word.
REQ-015 Port: out_err  output  1  word replaced by NOP due to an illegal request.
REQ-016 Port: out_count  output  16  number of words delivered since reset.

Function
REQ-017 Encoding SHALL follow RV32I: R={funct7,rs2,rs1,funct3,rd,opcode}; I={imm[11:0],rs1,funct3,rd,opcode}; S={imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}.
REQ-018 B={imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}; U={imm[31:12],rd,opcode}; J={imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}.
REQ-019 Range checks: I/S require imm within -2048..2047; B requires -4096..4094 and imm[0]=0; J requires -1048576..1048574 and imm[0]=0; U requires imm[11:0]=0.
REQ-020 Illegal fmt, or a failed range check, SHALL enqueue out_insn=32'h0000_0013 with out_err=1; otherwise out_err=0.
REQ-021 Encoding SHALL occur in the accept cycle; the result SHALL be written to a 2-entry FIFO of {err, insn}.
REQ-022 Latency: a request accepted at edge N into an empty FIFO SHALL present out_valid=1 from after edge N, i.e. one cycle.
REQ-023 in_ready SHALL be 1 iff the FIFO holds fewer than 2 entries, derived from registered state only (no combinational path from out_ready).
REQ-024 out_valid=1 iff the FIFO is non-empty; out_insn/out_err SHALL show the head entry and stay stable while out_valid & !out_ready.
REQ-025 Push and pop in the same cycle SHALL leave occupancy unchanged and preserve order; a pop with no entry, or a push when full, SHALL never occur.
REQ-026 FIFO pointers SHALL wrap modulo 2; occupancy SHALL be tracked as a 2-bit count 0..2.
REQ-027 out_count SHALL increment by 1 on each out_valid & out_ready, including error words, and SHALL wrap from 16'hFFFF to 0.

Reset
REQ-028 While reset=1 at an edge: FIFO emptied, out_valid=0, in_ready=1 after the edge, out_count=0, out_insn=0, out_err=0.
REQ-029 A reset asserted with entries pending SHALL discard them; no handshake SHALL complete in a reset cycle.

Verification
REQ-030 I-type fmt=1, opcode=0x13, funct3=0, rd=1, rs1=0, imm=5 -> out_insn=0x00500093, out_err=0, one cycle later.
REQ-031 S-type fmt=2, opcode=0x23, funct3=2, rs1=1, rs2=2, imm=8 -> 0x0020A423; B-type fmt=3, opcode=0x63, funct3=0, rs1=rs2=0, imm=-4 -> 0xFE000EE3.
REQ-032 J-type fmt=5, opcode=0x6F, rd=1, imm=8 -> 0x008000EF; B with imm=3, or I with imm=2048, or fmt=6 -> 0x00000013 with out_err=1.
REQ-033 Backpressure: out_ready=0, three back-to-back requests -> first two accepted, in_ready=0 on the third; release out_ready -> words emerge in order and the third is then accepted.
REQ-034 Stream 65537 words with out_ready=1 -> out_count=1; assert reset with 2 entries queued -> out_valid=0, out_count=0, in_ready=1 the next cycle.
